// File: rtl/ctrl_handoff_seq.sv
// rtl/ctrl_handoff_seq.sv - control-word sequencer granting datapath ownership to one sub-FSM at a time
module ctrl_handoff_seq #(
  parameter int NUM_FSM = 2,
  parameter int IDX_W = 3,
  parameter int CW_W = 21,
  parameter int ST_W = 8,
  parameter logic [ST_W-1:0] HANDOFF_CODE = ST_W'(8'hFF),
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_FSM*CW_W-1:0]  i_cw,
  input  logic [NUM_FSM*ST_W-1:0]  i_state,
  input  logic [NUM_FSM-1:0]       i_done,
  input  logic [NUM_FSM*IDX_W-1:0] i_next_sel,
  output logic [NUM_FSM-1:0]       o_start,
  output logic [CW_W-1:0]          o_cw,
  output logic [ST_W-1:0]          o_c_state,
  output logic [IDX_W-1:0]         o_owner,
  output logic [CNT_W-1:0]         o_handoff_cnt,
  output logic                     o_err,
  output logic                     o_timeout
);

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_RUN     = 2'd1,
    S_HANDOFF = 2'd2
  } state_t;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W:0] NUM_FSM_X = (IDX_W + 1)'(NUM_FSM);

  state_t state, state_nxt;
  // rst_q holds BOOT quiet (no start pulse) for the cycle right after a reset edge
  logic rst_q;
  logic [IDX_W-1:0] owner, tgt, tgt_nxt;
  logic [WD_W-1:0] wdog;
  logic [CNT_W-1:0] cnt;
  logic err, timeout;
  logic err_set, to_set;

  logic [CW_W-1:0] sel_cw;
  logic [ST_W-1:0] sel_st;
  logic sel_done;
  logic [IDX_W-1:0] sel_next;

  always_comb begin
    sel_cw = '0;
    sel_st = '0;
    sel_done = 1'b0;
    sel_next = '0;
    for (int k = 0; k < NUM_FSM; k++) begin
      if (owner == IDX_W'(k)) begin
        sel_cw = i_cw[k*CW_W +: CW_W];
        sel_st = i_state[k*ST_W +: ST_W];
        sel_done = i_done[k];
        sel_next = i_next_sel[k*IDX_W +: IDX_W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_BOOT;
      rst_q <= 1'b1;
    end else begin
      state <= state_nxt;
      rst_q <= 1'b0;
    end
  end

  // Owner completion beats the watchdog when both land in the same cycle
  always_comb begin
    state_nxt = state;
    tgt_nxt = tgt;
    err_set = 1'b0;
    to_set = 1'b0;
    case (state)
      S_BOOT: begin
        if (!rst_q) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (sel_done) begin
          state_nxt = S_HANDOFF;
          if ({1'b0, sel_next} >= NUM_FSM_X) begin
            tgt_nxt = '0;
            err_set = 1'b1;
          end else begin
            tgt_nxt = sel_next;
          end
        end else if ((TIMEOUT != 0) && (wdog == WD_LAST)) begin
          state_nxt = S_HANDOFF;
          tgt_nxt = '0;
          to_set = 1'b1;
        end
      end
      S_HANDOFF: state_nxt = S_RUN;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      owner <= '0;
      tgt <= '0;
      wdog <= '0;
      cnt <= '0;
      err <= 1'b0;
      timeout <= 1'b0;
    end else begin
      tgt <= tgt_nxt;
      if (err_set) begin
        err <= 1'b1;
      end
      if (to_set) begin
        timeout <= 1'b1;
      end
      if (state == S_RUN) begin
        wdog <= wdog + 1'b1;
      end
      if (state == S_HANDOFF) begin
        owner <= tgt;
        wdog <= '0;
        if (cnt != '1) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Outside RUN the datapath sees an all-zero word so no write enable leaks into the bubble
  always_comb begin
    o_start = '0;
    o_cw = '0;
    o_c_state = HANDOFF_CODE;
    case (state)
      S_RUN: begin
        o_cw = sel_cw;
        o_c_state = sel_st;
      end
      S_BOOT: begin
        if (!rst_q) begin
          o_start[0] = 1'b1;
        end
      end
      S_HANDOFF: begin
        for (int k = 0; k < NUM_FSM; k++) begin
          o_start[k] = (tgt == IDX_W'(k));
        end
      end
      default: begin
        o_start = '0;
      end
    endcase
  end

  assign o_owner = owner;
  assign o_handoff_cnt = cnt;
  assign o_err = err;
  assign o_timeout = timeout;

endmodule

// File: tb/tb_ctrl_handoff_seq.sv
// tb/tb_ctrl_handoff_seq.sv - scoreboard bench for ctrl_handoff_seq, two parameter sets
module tb_ctrl_handoff_seq;

  localparam int CW_W = 21;
  localparam int ST_W = 8;
  localparam int A_N = 3;
  localparam int A_IW = 2;
  localparam int B_N = 2;
  localparam int B_IW = 3;

  localparam logic [CW_W-1:0] A_CW0 = 21'h01111;
  localparam logic [CW_W-1:0] A_CW1 = 21'h02222;
  localparam logic [CW_W-1:0] A_CW2 = 21'h03333;
  localparam logic [CW_W-1:0] B_CW0 = 21'h1ABCD;
  localparam logic [CW_W-1:0] B_CW1 = 21'h05432;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  a_rst;
  logic [A_N*CW_W-1:0]   a_cw;
  logic [A_N*ST_W-1:0]   a_st;
  logic [A_N-1:0]        a_done;
  logic [A_N*A_IW-1:0]   a_sel;
  logic [A_N-1:0]        a_start;
  logic [CW_W-1:0]       a_ocw;
  logic [ST_W-1:0]       a_ost;
  logic [A_IW-1:0]       a_owner;
  logic [1:0]            a_cnt;
  logic                  a_err, a_to;

  logic                  b_rst;
  logic [B_N*CW_W-1:0]   b_cw;
  logic [B_N*ST_W-1:0]   b_st;
  logic [B_N-1:0]        b_done;
  logic [B_N*B_IW-1:0]   b_sel;
  logic [B_N-1:0]        b_start;
  logic [CW_W-1:0]       b_ocw;
  logic [ST_W-1:0]       b_ost;
  logic [B_IW-1:0]       b_owner;
  logic [15:0]           b_cnt;
  logic                  b_err, b_to;

  ctrl_handoff_seq #(
    .NUM_FSM(A_N), .IDX_W(A_IW), .CW_W(CW_W), .ST_W(ST_W),
    .HANDOFF_CODE(8'hFF), .TIMEOUT(4), .CNT_W(2)
  ) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_cw(a_cw), .i_state(a_st),
    .i_done(a_done), .i_next_sel(a_sel), .o_start(a_start), .o_cw(a_ocw),
    .o_c_state(a_ost), .o_owner(a_owner), .o_handoff_cnt(a_cnt),
    .o_err(a_err), .o_timeout(a_to)
  );

  ctrl_handoff_seq #(
    .NUM_FSM(B_N), .IDX_W(B_IW), .CW_W(CW_W), .ST_W(ST_W),
    .HANDOFF_CODE(8'hFF), .TIMEOUT(0), .CNT_W(16)
  ) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_cw(b_cw), .i_state(b_st),
    .i_done(b_done), .i_next_sel(b_sel), .o_start(b_start), .o_cw(b_ocw),
    .o_c_state(b_ost), .o_owner(b_owner), .o_handoff_cnt(b_cnt),
    .o_err(b_err), .o_timeout(b_to)
  );

  typedef struct {
    string       tag;
    logic [31:0] start;
    logic [31:0] cw;
    logic [31:0] st;
    logic [31:0] owner;
    logic [31:0] cnt;
    logic [31:0] err;
    logic [31:0] to;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int n_checks = 0;
  int n_fails = 0;

  task automatic chk(string tag, string fld, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, fld, act, exp);
    end
  endtask

  task automatic cmp(exp_t e, logic [31:0] start, logic [31:0] cw, logic [31:0] st,
                     logic [31:0] owner, logic [31:0] cnt, logic [31:0] err, logic [31:0] to);
    chk(e.tag, "o_start", start, e.start);
    chk(e.tag, "o_cw", cw, e.cw);
    chk(e.tag, "o_c_state", st, e.st);
    chk(e.tag, "o_owner", owner, e.owner);
    chk(e.tag, "o_handoff_cnt", cnt, e.cnt);
    chk(e.tag, "o_err", err, e.err);
    chk(e.tag, "o_timeout", to, e.to);
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      cmp(ea, 32'(a_start), 32'(a_ocw), 32'(a_ost), 32'(a_owner), 32'(a_cnt), 32'(a_err), 32'(a_to));
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      cmp(eb, 32'(b_start), 32'(b_ocw), 32'(b_ost), 32'(b_owner), 32'(b_cnt), 32'(b_err), 32'(b_to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pa(string tag, int start, int cw, int st, int owner, int cnt, int err, int to);
    exp_t e;
    e.tag = tag; e.start = start; e.cw = cw; e.st = st;
    e.owner = owner; e.cnt = cnt; e.err = err; e.to = to;
    qa.push_back(e);
  endtask

  task automatic pb(string tag, int start, int cw, int st, int owner, int cnt, int err, int to);
    exp_t e;
    e.tag = tag; e.start = start; e.cw = cw; e.st = st;
    e.owner = owner; e.cnt = cnt; e.err = err; e.to = to;
    qb.push_back(e);
  endtask

  // Instance A: NUM_FSM=3, TIMEOUT=4, CNT_W=2
  task automatic run_a();
    a_rst = 1'b1; a_done = '0; a_sel = '0;
    a_cw = {A_CW2, A_CW1, A_CW0};
    a_st = {8'h32, 8'h31, 8'h30};
    tick();
    a_rst = 1'b0;
    pa("a_rst", 0, 0, 'hFF, 0, 0, 0, 0);
    tick(); pa("a_boot", 1, 0, 'hFF, 0, 0, 0, 0);
    tick(); a_done[1] = 1'b1; a_sel[2 +: 2] = 2'd2;
    pa("a_ignore", 0, A_CW0, 'h30, 0, 0, 0, 0);
    tick(); a_done = '0; pa("a_run2", 0, A_CW0, 'h30, 0, 0, 0, 0);
    tick(); pa("a_run3", 0, A_CW0, 'h30, 0, 0, 0, 0);
    tick(); a_done[0] = 1'b1; a_sel[0 +: 2] = 2'd1;
    pa("a_run4_done", 0, A_CW0, 'h30, 0, 0, 0, 0);
    tick(); a_done = '0; pa("a_ho_coincide", 'b010, 0, 'hFF, 0, 0, 0, 0);
    tick(); a_done[1] = 1'b1; a_sel[2 +: 2] = 2'd3;
    pa("a_own1", 0, A_CW1, 'h31, 1, 1, 0, 0);
    tick(); a_done = '0; pa("a_ho_bad", 'b001, 0, 'hFF, 1, 1, 1, 0);
    tick(); pa("a_own0", 0, A_CW0, 'h30, 0, 2, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); pa("a_wd_run", 0, A_CW0, 'h30, 0, 2, 1, 0);
    end
    tick(); pa("a_ho_wdog", 'b001, 0, 'hFF, 0, 2, 1, 1);
    tick(); a_done[0] = 1'b1; a_sel[0 +: 2] = 2'd2;
    pa("a_cnt3", 0, A_CW0, 'h30, 0, 3, 1, 1);
    tick(); a_done = '0; pa("a_ho_to2", 'b100, 0, 'hFF, 0, 3, 1, 1);
    tick(); a_done[2] = 1'b1; a_sel[4 +: 2] = 2'd2;
    pa("a_own2", 0, A_CW2, 'h32, 2, 3, 1, 1);
    tick(); a_done = '0; pa("a_ho_self", 'b100, 0, 'hFF, 2, 3, 1, 1);
    tick(); a_done[2] = 1'b1; a_sel[4 +: 2] = 2'd0;
    pa("a_sat", 0, A_CW2, 'h32, 2, 3, 1, 1);
    tick(); a_done = '0; a_rst = 1'b1;
    pa("a_ho_rst", 'b001, 0, 'hFF, 2, 3, 1, 1);
    tick(); a_rst = 1'b0; pa("a_rst2", 0, 0, 'hFF, 0, 0, 0, 0);
    tick(); pa("a_boot2", 1, 0, 'hFF, 0, 0, 0, 0);
    tick(); pa("a_run_post", 0, A_CW0, 'h30, 0, 0, 0, 0);
  endtask

  // Instance B: NUM_FSM=2, TIMEOUT=0 (watchdog off), CNT_W=16
  task automatic run_b();
    b_rst = 1'b1; b_done = '0; b_sel = '0;
    b_cw = {B_CW1, B_CW0};
    b_st = {8'h41, 8'h40};
    tick();
    b_rst = 1'b0;
    pb("b_rst", 0, 0, 'hFF, 0, 0, 0, 0);
    tick(); pb("b_boot", 1, 0, 'hFF, 0, 0, 0, 0);
    for (int i = 0; i < 70; i++) begin
      tick();
      b_cw[0 +: CW_W] = CW_W'(i * 'h1357 + 5);
      b_done[1] = i[0];
      b_sel[3 +: 3] = 3'd0;
      pb("b_track", 0, i * 'h1357 + 5, 'h40, 0, 0, 0, 0);
    end
    tick(); b_cw[0 +: CW_W] = B_CW0; b_done = 2'b01; b_sel[0 +: 3] = 3'd1;
    pb("b_req", 0, B_CW0, 'h40, 0, 0, 0, 0);
    tick(); b_done = '0; pb("b_ho", 'b10, 0, 'hFF, 0, 0, 0, 0);
    tick(); b_done[1] = 1'b1; b_sel[3 +: 3] = 3'd5;
    pb("b_own1", 0, B_CW1, 'h41, 1, 1, 0, 0);
    tick(); b_done = '0; pb("b_ho_bad", 'b01, 0, 'hFF, 1, 1, 1, 0);
    tick(); pb("b_own0", 0, B_CW0, 'h40, 0, 2, 1, 0);
    tick(); pb("b_own0_hold", 0, B_CW0, 'h40, 0, 2, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit: bench did not reach its end, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    fork
      run_a();
      run_b();
    join
    tick();
    tick();
    chk("drain", "qa_left", 32'(qa.size()), 0);
    chk("drain", "qb_left", 32'(qb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
